// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: instruction memory answering fetch requests over valid/ready after WAIT_CYCLES wait states.
// Define IMEM_BOUNDS_CHECK_EN to add rsp_fault for addresses beyond the array instead of aliasing.
module imem_fetch_responder #(
    parameter int ADDR_W      = 30,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic [ADDR_W-1:0]     rsp_addr,
`ifdef IMEM_BOUNDS_CHECK_EN
    output logic                  rsp_fault,
`endif
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              accept, capture;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       mem [0:(1<<DEPTH_LOG2)-1];

    // Zero-wait reads use the live request; otherwise the address latched at acceptance.
    assign rd_addr   = state == IDLE ? req_addr : rsp_addr;
    assign req_ready = state == IDLE && !load_en;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;

`ifdef IMEM_BOUNDS_CHECK_EN
    logic oob;
    assign oob = |rd_addr[ADDR_W-1:DEPTH_LOG2];
`else
    logic unused_hi;
    assign unused_hi = ^rd_addr[ADDR_W-1:DEPTH_LOG2];
`endif

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: if (req_valid && req_ready) begin
                accept   = 1'b1;
                capture  = WAIT_CYCLES == 0;
                state_nx = WAIT_CYCLES == 0 ? RESP : WAIT;
            end
            WAIT: if (cnt == 4'd1) begin
                capture  = 1'b1;
                state_nx = RESP;
            end
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_instr <= '0;
            rsp_addr  <= '0;
`ifdef IMEM_BOUNDS_CHECK_EN
            rsp_fault <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                rsp_addr <= req_addr;
                cnt      <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
`ifdef IMEM_BOUNDS_CHECK_EN
                rsp_fault <= oob;
                rsp_instr <= oob ? 32'h0 : mem[rd_addr[DEPTH_LOG2-1:0]];
`else
                rsp_instr <= mem[rd_addr[DEPTH_LOG2-1:0]];
`endif
            end
        end
    end

    // Loader write shares the edge with a read: the read sees the old word.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: three responders (0, 1 and 3 wait states) checked against a memory-array model via a scoreboard.
// Honours IMEM_BOUNDS_CHECK_EN to expect faults instead of aliasing.
module tb_imem_fetch_responder;
    localparam int AW = 30;
    localparam int DL = 10;
    localparam int NI = 3;

    function automatic int wc_of(input int i);
        return i == 0 ? 0 : (i == 1 ? 1 : 3);
    endfunction

    typedef struct {
        int          inst;
        logic [AW-1:0] addr;
        logic [31:0] instr;
        logic        fault;
        int          acc;
    } exp_t;

    logic          clk = 0;
    logic          rst_n = 1;
    logic [NI-1:0] req_valid = '0, rsp_ready = '0;
    logic [NI-1:0] req_ready, rsp_valid, busy, rsp_fault;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] rsp_addr [NI];
    logic [31:0]   rsp_instr [NI];
    logic          load_en = 0;
    logic [DL-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;

    logic [31:0] mm [0:(1<<DL)-1];
    exp_t        q[$];
    int          checks = 0, errors = 0, cyc = 0;
    bit          shown = 0, bp_rand = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        imem_fetch_responder #(.ADDR_W(AW), .DEPTH_LOG2(DL), .WAIT_CYCLES(wc_of(g))) dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_instr(rsp_instr[g]), .rsp_addr(rsp_addr[g]),
`ifdef IMEM_BOUNDS_CHECK_EN
            .rsp_fault(rsp_fault[g]),
`endif
            .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
            .busy(busy[g]));
    end
`ifndef IMEM_BOUNDS_CHECK_EN
    assign rsp_fault = '0;
`endif

    function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", n, act, req, $time);
        end
    endfunction

    // Reference: the word last loaded at the address's index, or a fault beyond the array when checking is on.
    function automatic exp_t model(input int i, input logic [AW-1:0] a, input int acc);
        exp_t e;
        e.inst = i;
        e.addr = a;
        e.acc  = acc;
`ifdef IMEM_BOUNDS_CHECK_EN
        e.fault = a >= AW'(1 << DL);
`else
        e.fault = 1'b0;
`endif
        e.instr = e.fault ? 32'h0 : mm[DL'(a % (1 << DL))];
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) shown <= 0;
        else for (int i = 0; i < NI; i++) if (rsp_valid[i]) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: inst %0d addr %h got valid, required none", i, rsp_addr[i]);
            end else begin
                chk("rsp_inst", 64'(i), 64'(q[0].inst));
                if (!shown) chk("latency", 64'(cyc - q[0].acc), 64'(wc_of(i)));
                chk("rsp_instr", rsp_instr[i], q[0].instr);
                chk("rsp_addr", rsp_addr[i], q[0].addr);
                chk("rsp_fault", rsp_fault[i], q[0].fault);
                chk("rsp_req_ready", req_ready[i], 0);
                chk("rsp_busy", busy[i], 1);
                if (rsp_ready[i]) begin
                    void'(q.pop_front());
                    shown <= 0;
                end else shown <= 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (bp_rand) rsp_ready = NI'($urandom);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] d, input bit check);
        load_en   = 1;
        load_addr = DL'(idx);
        load_data = d;
        mm[idx]   = d;
        @(negedge clk);
        if (check) begin
            chk("load_req_ready", req_ready, 0);
            chk("load_rsp_valid", rsp_valid, 0);
        end
        tick;
        load_en = 0;
    endtask

    task automatic fetch(input int i, input logic [AW-1:0] a, input bit keep, output int acc);
        int n = 0;
        req_valid[i] = 1;
        req_addr     = a;
        @(negedge clk);
        while (!req_ready[i] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: inst %0d got no req_ready in %0d cycles, required acceptance", i, n);
            req_valid[i] = 0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        q.push_back(model(i, a, acc));
        tick;
        if (!keep) req_valid[i] = 0;
    endtask

    task automatic drain;
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            tick;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int acc, n;
        int accs [4];
        logic [AW-1:0] a;
        #1 rst_n = 0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("rst_rsp_valid", rsp_valid[i], 0);
                chk("rst_busy", busy[i], 0);
                chk("rst_req_ready", req_ready[i], 1);
                chk("rst_rsp_instr", rsp_instr[i], 0);
                chk("rst_rsp_addr", rsp_addr[i], 0);
                chk("rst_rsp_fault", rsp_fault[i], 0);
            end
        end
        tick;
        rst_n = 1;
        for (int k = 0; k < 4; k++) load(k, 32'h1111_0000 + k, 1);
        for (int k = 4; k < 64; k++) load(k, $urandom, 1);

        rsp_ready = '1;
        fetch(1, 2, 0, acc);
        drain;
        chk("basic_instr_literal", mm[2], 32'h1111_0002);
        @(negedge clk);
        chk("basic_req_ready_back", req_ready[1], 1);

        // Load at the read edge must not be seen; load during the held response must not disturb it.
        tick;
        rsp_ready[1] = 0;
        fetch(1, 3, 0, acc);
        load(3, 32'hDEAD_0003, 0);
        load(3, 32'hBEEF_0003, 0);
        n = 0;
        while (!rsp_valid[1] && n < 20) begin
            tick;
            n++;
        end
        repeat (5) tick;
        chk("bp_still_valid", rsp_valid[1], 1);
        rsp_ready[1] = 1;
        drain;
        fetch(1, 3, 0, acc);
        drain;
        load(3, 32'h1111_0003, 1);

        for (int k = 0; k < 4; k++) fetch(0, AW'(k), 1, accs[k]);
        req_valid[0] = 0;
        drain;
        for (int k = 1; k < 4; k++) chk("b2b_spacing", 64'(accs[k] - accs[k-1]), 2);

        fetch(2, 2, 0, acc);
        tick;
        #3;
        rst_n = 0;
        q.delete();
        #1;
        chk("async_rst_busy", busy[2], 0);
        chk("async_rst_valid", rsp_valid[2], 0);
        repeat (2) tick;
        rst_n = 1;
        repeat (6) tick;
        fetch(2, 1, 0, acc);
        drain;

        fetch(1, 30'h400, 0, acc);
        drain;
        fetch(1, 3, 0, acc);
        drain;

        bp_rand = 1;
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 20; k++) begin
                a = AW'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) a[AW-1:DL] = (AW-DL)'($urandom);
                fetch(i, a, 0, acc);
            end
            drain;
        end
        bp_rand = 0;
        tick;
        rsp_ready = '1;
        drain;
        repeat (3) tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
